// File: rtl/sc_fir_pkg.sv
// Shared types, sizes and helpers for the stochastic-computing FIR evaluation stage.
package sc_fir_pkg;

  localparam int N     = 8;
  localparam int TAPS  = 39;
  localparam int SEL_W = $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef logic [N-1:0] sample_t;
  typedef logic [N:0]   acc_t;

  localparam sample_t SAMPLE_MAX = {N{1'b1}};

  // Bit-reversed ramp decorrelates the coefficient stream from the tap stream.
  function automatic sample_t bitrev(input sample_t v);
    sample_t o;
    for (int i = 0; i < N; i++) begin
      o[i] = v[N-1-i];
    end
    return o;
  endfunction

endpackage

// File: rtl/sc_fir_eval_if.sv
// Request/result bundle between the tap delay line and the FIR evaluation stage.
interface sc_fir_eval_if;
  import sc_fir_pkg::*;

  logic    start;
  sample_t taps [TAPS];
  sample_t coef [TAPS];
  logic    busy;
  logic    done;
  sample_t result;

  modport master (output start, taps, coef, input busy, done, result);
  modport slave  (input start, taps, coef, output busy, done, result);
endinterface

// File: rtl/sc_sng.sv
// Comparator stream generator: emits 1 while the shared ramp is below the value.
module sc_sng
  import sc_fir_pkg::*;
(
  input  sample_t value_i,
  input  sample_t rnd_i,
  output logic    bit_o
);
  assign bit_o = (rnd_i < value_i);
endmodule

// File: rtl/sc_fir_eval.sv
// Stochastic FIR evaluation: AND-multiply tap/coef streams, rotate-select one product per
// cycle and count ones over a 2^N-cycle window, saturating to an N-bit result.
module sc_fir_eval
  import sc_fir_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  sc_fir_eval_if.slave  bus
);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  sample_t          result_q;
  sample_t          r_q;
  logic [SEL_W-1:0] sel_q;
  acc_t             acc_q;
  sample_t          tap_q  [TAPS];
  sample_t          coef_q [TAPS];

  sample_t          r_rev;
  logic [TAPS-1:0]  x_bits;
  logic [TAPS-1:0]  w_bits;
  logic [TAPS-1:0]  prod;
  logic             p_sel;
  acc_t             acc_d;
  logic [SEL_W-1:0] sel_d;
  sample_t          result_d;

  assign r_rev = bitrev(r_q);

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_sng
      sc_sng u_tap_sng  (.value_i(tap_q[gi]),  .rnd_i(r_q),   .bit_o(x_bits[gi]));
      sc_sng u_coef_sng (.value_i(coef_q[gi]), .rnd_i(r_rev), .bit_o(w_bits[gi]));
    end
  endgenerate

  assign prod     = x_bits & w_bits;
  assign p_sel    = prod[sel_q];
  assign acc_d    = acc_q + acc_t'(p_sel);
  assign sel_d    = (sel_q == SEL_W'(TAPS-1)) ? '0 : sel_q + 1'b1;
  // acc can only reach 2^N, so its top bit alone marks overflow.
  assign result_d = acc_q[N] ? SAMPLE_MAX : acc_q[N-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      r_q      <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        tap_q[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          for (int i = 0; i < TAPS; i++) begin
            tap_q[i]  <= bus.taps[i];
            coef_q[i] <= bus.coef[i];
          end
          r_q     <= '0;
          sel_q   <= '0;
          acc_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          r_q   <= r_q + 1'b1;
          sel_q <= sel_d;
          if (r_q == SAMPLE_MAX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_sc_fir_eval.sv
// Self-checking bench for sc_fir_eval: table vectors, hand-written corner sequences, random runs.
module tb_sc_fir_eval;
  import sc_fir_pkg::*;

  localparam int LATENCY = (1 << N) + 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sc_fir_eval_if bus();

  sc_fir_eval dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    sample_t tap_all;
    sample_t coef_all;
    sample_t tap0;
    sample_t coef0;
    logic [N:0] exp;
  } vec_t;

  vec_t    vecs [7];
  sample_t tap_v  [TAPS];
  sample_t coef_v [TAPS];
  int      exp_q [$];
  int      checks = 0;
  int      errors = 0;
  int      done_seen = 0;
  int      mon_exp;
  int      lat;
  int      seen_before;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int bitrev_ref(input int v);
    int o = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) o = o | (1 << (N - 1 - i));
    end
    return o;
  endfunction

  // Reference: one product per ramp step, chosen by a rotating tap select.
  function automatic int model();
    int acc = 0;
    int sel = 0;
    for (int r = 0; r < (1 << N); r++) begin
      if ((r < int'(tap_v[sel])) && (bitrev_ref(r) < int'(coef_v[sel]))) acc++;
      sel = (sel + 1) % TAPS;
    end
    return (acc > (1 << N) - 1) ? (1 << N) - 1 : acc;
  endfunction

  always @(negedge clock) begin
    if (reset_n && bus.done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %0d, expected no done pulse", bus.result);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", int'(bus.result), mon_exp);
        $display("eval done: result=%0d expected=%0d", bus.result, mon_exp);
      end
    end
  end

  task automatic drive_bus();
    for (int i = 0; i < TAPS; i++) begin
      bus.taps[i] = tap_v[i];
      bus.coef[i] = coef_v[i];
    end
  endtask

  task automatic start_eval(input bit push, input int expected, input bit now);
    drive_bus();
    if (push) exp_q.push_back(expected);
    if (!now) @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    #1 bus.start = 1'b0;
  endtask

  // lat counts cycles after the accepting edge; taps are scrambled after LOAD on purpose.
  task automatic wait_done(input int pulse_at, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clock);
      cycles++;
      if (cycles == 3) begin
        for (int i = 0; i < TAPS; i++) bus.taps[i] = sample_t'($urandom_range(0, 255));
      end
      if (cycles == 10) check("busy_mid_run", int'(bus.busy), 1);
      if (pulse_at > 0 && cycles == pulse_at) bus.start = 1'b1;
      if (pulse_at > 0 && cycles == pulse_at + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) break;
      if (cycles > 2 * LATENCY) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected %0d", cycles, LATENCY);
        break;
      end
    end
  endtask

  task automatic finish_checks(input int cycles);
    check("latency", cycles, LATENCY);
    check("busy_at_done", int'(bus.busy), 0);
    @(negedge clock);
    check("busy_after_done", int'(bus.busy), 0);
    check("done_one_cycle", int'(bus.done), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      bus.taps[i] = '0;
      bus.coef[i] = '0;
    end

    vecs[0] = '{tap_all: 8'd0,   coef_all: 8'd255, tap0: 8'd0,   coef0: 8'd255, exp: 9'd0};
    vecs[1] = '{tap_all: 8'd255, coef_all: 8'd255, tap0: 8'd255, coef0: 8'd255, exp: 9'd255};
    vecs[2] = '{tap_all: 8'd0,   coef_all: 8'd0,   tap0: 8'd255, coef0: 8'd255, exp: 9'd7};
    vecs[3] = '{tap_all: 8'd255, coef_all: 8'd128, tap0: 8'd255, coef0: 8'd128, exp: 9'd128};
    vecs[4] = '{tap_all: 8'd128, coef_all: 8'd255, tap0: 8'd128, coef0: 8'd255, exp: 9'd128};
    vecs[5] = '{tap_all: 8'd255, coef_all: 8'd0,   tap0: 8'd255, coef0: 8'd0,   exp: 9'd0};
    vecs[6] = '{tap_all: 8'd0,   coef_all: 8'd0,   tap0: 8'd128, coef0: 8'd255, exp: 9'd4};

    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_result", int'(bus.result), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < TAPS; i++) begin
        tap_v[i]  = (i == 0) ? vecs[v].tap0  : vecs[v].tap_all;
        coef_v[i] = (i == 0) ? vecs[v].coef0 : vecs[v].coef_all;
      end
      $display("vector %0d: tap_all=%0d coef_all=%0d tap0=%0d coef0=%0d", v,
               vecs[v].tap_all, vecs[v].coef_all, vecs[v].tap0, vecs[v].coef0);
      start_eval(1'b1, int'(vecs[v].exp), 1'b0);
      wait_done(0, lat);
      finish_checks(lat);
    end

    // Reset at RUN cycle 100: abort, no done, result cleared.
    for (int i = 0; i < TAPS; i++) begin
      tap_v[i]  = 8'd200;
      coef_v[i] = 8'd200;
    end
    seen_before = done_seen;
    start_eval(1'b0, 0, 1'b0);
    repeat (102) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_result", int'(bus.result), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (300) @(negedge clock);
    check("abort_no_done", done_seen - seen_before, 0);
    check("abort_result_held", int'(bus.result), 0);
    $display("reset abort: busy=%0d result=%0d", bus.busy, bus.result);

    // Start during RUN is dropped; a start one cycle after done begins a fresh evaluation.
    for (int i = 0; i < TAPS; i++) begin
      tap_v[i]  = sample_t'($urandom_range(0, 255));
      coef_v[i] = sample_t'($urandom_range(0, 255));
    end
    seen_before = done_seen;
    start_eval(1'b1, model(), 1'b0);
    wait_done(50, lat);
    finish_checks(lat);
    for (int i = 0; i < TAPS; i++) tap_v[i] = sample_t'($urandom_range(0, 255));
    start_eval(1'b1, model(), 1'b1);
    wait_done(0, lat);
    finish_checks(lat);
    repeat (2 * LATENCY) @(negedge clock);
    check("retrigger_eval_count", done_seen - seen_before, 2);

    for (int run = 0; run < 200; run++) begin
      for (int i = 0; i < TAPS; i++) begin
        case (run % 4)
          0:       tap_v[i] = sample_t'($urandom_range(0, 255));
          1:       tap_v[i] = sample_t'($urandom_range(200, 255));
          2:       tap_v[i] = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'd0;
          default: tap_v[i] = sample_t'($urandom_range(0, 64));
        endcase
        coef_v[i] = sample_t'($urandom_range(0, 255));
      end
      start_eval(1'b1, model(), 1'b0);
      wait_done(0, lat);
      check("rand_latency", lat, LATENCY);
    end
    repeat (2) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
